rb_bank_ctrl: RTL and testbench

Ring-buffer controller for four interleaved 8-bit BRAM banks. Entries are striped round-robin across the banks: entry k lives in bank k mod 4 at word k div 4. The block owns the write and read pointers, drives bank write/read strobes and addresses, and produces `mux_sel`/`mux_en` for the downstream `mux_4_to_1`, aligned to BRAM read latency. It presents a valid/ready stream on both sides.

---
 rtl/rb_pkg.sv | 18 +
 rtl/rb_ptr.sv | 30 +++
 rtl/rb_bank_ctrl.sv | 139 +++++++++++++
 tb/tb_rb_bank_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared constants and helpers for the four-bank ring-buffer controller.
package rb_pkg;

  localparam int unsigned RB_BANKS  = 4;
  localparam int unsigned RB_BANK_W = 2;
  localparam int unsigned RB_DATA_W = 8;

  typedef logic [RB_BANKS-1:0] rb_bank_mask_t;

  // 2-bit bank index to one-hot bank strobe.
  function automatic rb_bank_mask_t rb_onehot4(input logic [RB_BANK_W-1:0] sel);
    rb_bank_mask_t oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rb_ptr.sv
// Wrapping ring-buffer pointer split into bank (low bits) and word (high bits).
module rb_ptr
  import rb_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [RB_BANK_W-1:0] bank,
  output logic [ADDR_W-1:0]    word
);

  localparam int unsigned PtrW = ADDR_W + RB_BANK_W;

  logic [PtrW-1:0] ptr_q;

  // Pointer register; wraps naturally at the full bank*word depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + PtrW'(1);
    end
  end

  assign bank = ptr_q[RB_BANK_W-1:0];
  assign word = ptr_q[PtrW-1:RB_BANK_W];

endmodule

// File: rtl/rb_bank_ctrl.sv
// Ring-buffer controller striping entries round-robin over four BRAM banks.
// Optional feature macro: RB_ALMOST_FULL_EN (registered almost_full output).
module rb_bank_ctrl
  import rb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned AF_THRESH = (RB_BANKS << ADDR_W) - 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [RB_DATA_W-1:0] wr_data,
  output logic                 wr_ready,
  output logic [RB_BANKS-1:0]  bank_we,
  output logic [ADDR_W-1:0]    bank_waddr,
  output logic [RB_DATA_W-1:0] bank_wdata,
  output logic [RB_BANKS-1:0]  bank_re,
  output logic [ADDR_W-1:0]    bank_raddr,
  output logic [RB_BANK_W-1:0] mux_sel,
  output logic                 mux_en,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [ADDR_W+2:0]    count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full
);

  localparam int unsigned DEPTH = RB_BANKS << ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 3;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [CntW-1:0]      count_q, count_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [RB_BANK_W-1:0] mux_sel_q, mux_sel_d;
  logic                 wa, ri;
  logic [RB_BANK_W-1:0] wbank, rbank;
  logic [ADDR_W-1:0]    wword, rword;

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign wr_ready = !full && !rst;
  assign wa       = wr_valid && wr_ready;
  // Issue a read whenever the output stage is free or being emptied this cycle.
  assign ri       = !empty && (!rd_valid_q || rd_ready);

  rb_ptr #(
    .ADDR_W(ADDR_W)
  ) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wa),
    .bank(wbank),
    .word(wword)
  );

  rb_ptr #(
    .ADDR_W(ADDR_W)
  ) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (ri),
    .bank(rbank),
    .word(rword)
  );

  // Combinational bank strobes and addresses for the current accept/issue.
  always_comb begin
    bank_we    = '0;
    bank_re    = '0;
    bank_waddr = wword;
    bank_raddr = rword;
    bank_wdata = wr_data;
    if (wa) begin
      bank_we = rb_onehot4(wbank);
    end
    if (ri) begin
      bank_re = rb_onehot4(rbank);
    end
  end

  // Next-state for occupancy and the read output stage.
  always_comb begin
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    mux_sel_d  = mux_sel_q;
    if (wa && !ri) begin
      count_d = count_q + CntW'(1);
    end else if (ri && !wa) begin
      count_d = count_q - CntW'(1);
    end
    if (ri) begin
      rd_valid_d = 1'b1;
      mux_sel_d  = rbank;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      mux_sel_q  <= '0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      mux_sel_q  <= mux_sel_d;
    end
  end

  assign count    = count_q;
  assign rd_valid = rd_valid_q;
  assign mux_en   = rd_valid_q;
  assign mux_sel  = mux_sel_q;

`ifdef RB_ALMOST_FULL_EN
  localparam logic [CntW-1:0] CntAf = CntW'(AF_THRESH);

  logic almost_full_q;

  // Registered almost-full, computed from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (count_d >= CntAf);
    end
  end

  assign almost_full = almost_full_q;
`else
  logic unused_af_thresh;
  assign unused_af_thresh = ^AF_THRESH;
  assign almost_full      = 1'b0;
`endif

endmodule

// File: tb/tb_rb_bank_ctrl.sv
// Self-checking bench for rb_bank_ctrl at depth 16 (ADDR_W = 2, AF_THRESH = 12).
module tb_rb_bank_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 16;
  localparam int WORDS = 4;
  localparam int AFT   = 12;
`ifdef RB_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic [3:0]    bank_we;
  logic [AW-1:0] bank_waddr;
  logic [7:0]    bank_wdata;
  logic [3:0]    bank_re;
  logic [AW-1:0] bank_raddr;
  logic [1:0]    mux_sel;
  logic          mux_en;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW+2:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;

  int errors = 0;
  int checks = 0;

  rb_bank_ctrl #(
    .ADDR_W   (AW),
    .AF_THRESH(AFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .bank_we    (bank_we),
    .bank_waddr (bank_waddr),
    .bank_wdata (bank_wdata),
    .bank_re    (bank_re),
    .bank_raddr (bank_raddr),
    .mux_sel    (mux_sel),
    .mux_en     (mux_en),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Environment: four 1-cycle-latency BRAMs with output registers, plus the 4:1 mux.
  logic [7:0] mem  [4][WORDS];
  logic [7:0] dout [4];
  logic [7:0] mux_out;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_we[b]) mem[b][bank_waddr] <= bank_wdata;
      if (bank_re[b]) dout[b] <= mem[b][bank_raddr];
    end
  end

  assign mux_out = mux_en ? dout[mux_sel] : 8'h00;

  // Reference model: occupancy of unissued entries, output-stage flag, totals, data FIFO.
  int         m_n;
  bit         m_ov;
  int         m_wtot;
  int         m_rtot;
  int         m_sel;
  bit         m_af;
  logic [7:0] m_q[$];

  task automatic model_reset();
    m_n = 0; m_ov = 0; m_wtot = 0; m_rtot = 0; m_sel = 0; m_af = 0;
    m_q.delete();
  endtask

  // One clock cycle: compare all outputs against the model, then advance it.
  task automatic tick();
    bit         e_wa, e_ri;
    logic [3:0] e_we, e_re;
    logic [7:0] e_d;
    @(negedge clk);
    e_wa = wr_valid && (m_n < DEPTH);
    e_ri = (m_n > 0) && (!m_ov || rd_ready);
    e_we = e_wa ? 4'(1 << (m_wtot % 4)) : 4'b0000;
    e_re = e_ri ? 4'(1 << (m_rtot % 4)) : 4'b0000;
    checks += 7;
    if (bank_we !== e_we) begin
      errors++; $display("FAIL bank_we: got %b want %b", bank_we, e_we);
    end
    if (bank_re !== e_re) begin
      errors++; $display("FAIL bank_re: got %b want %b", bank_re, e_re);
    end
    if ({wr_ready, full, empty} !== {m_n < DEPTH, m_n == DEPTH, m_n == 0}) begin
      errors++;
      $display("FAIL flags: got rdy/full/empty %b want %b", {wr_ready, full, empty},
               {m_n < DEPTH, m_n == DEPTH, m_n == 0});
    end
    if (count !== 5'(m_n)) begin
      errors++; $display("FAIL count: got %0d want %0d", count, m_n);
    end
    if ({rd_valid, mux_en} !== {m_ov, m_ov}) begin
      errors++; $display("FAIL rd_valid/mux_en: got %b want %b", {rd_valid, mux_en}, {m_ov, m_ov});
    end
    if (almost_full !== m_af) begin
      errors++; $display("FAIL almost_full: got %b want %b", almost_full, m_af);
    end
    if (bank_wdata !== wr_data) begin
      errors++; $display("FAIL bank_wdata: got %h want %h", bank_wdata, wr_data);
    end
    if (e_wa) begin
      checks++;
      if (bank_waddr !== AW'((m_wtot / 4) % WORDS)) begin
        errors++; $display("FAIL bank_waddr: got %0d want %0d", bank_waddr, (m_wtot / 4) % WORDS);
      end
    end
    if (e_ri) begin
      checks++;
      if (bank_raddr !== AW'((m_rtot / 4) % WORDS)) begin
        errors++; $display("FAIL bank_raddr: got %0d want %0d", bank_raddr, (m_rtot / 4) % WORDS);
      end
    end
    if (m_ov) begin
      checks++;
      if (mux_sel !== 2'(m_sel)) begin
        errors++; $display("FAIL mux_sel: got %0d want %0d", mux_sel, m_sel);
      end
    end
    if (m_ov && rd_ready) begin
      checks++;
      e_d = (m_q.size() > 0) ? m_q.pop_front() : 8'hxx;
      if (mux_out !== e_d) begin
        errors++; $display("FAIL read_data: got %h want %h", mux_out, e_d);
      end
    end
    if (e_wa) begin
      m_q.push_back(wr_data);
      m_wtot++;
    end
    if (e_ri) begin
      m_sel = m_rtot % 4;
      m_rtot++;
      m_ov = 1;
    end else if (m_ov && rd_ready) begin
      m_ov = 0;
    end
    m_n = m_n + int'(e_wa) - int'(e_ri);
    m_af = AF_ON && (m_n >= AFT);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain_all();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 60 && (m_n > 0 || m_ov); i++) tick();
    checks++;
    if (!(empty === 1'b1 && rd_valid === 1'b0)) begin
      errors++; $display("FAIL drain_timeout: got empty=%b rd_valid=%b want 1 0", empty, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({count, empty, full, almost_full, wr_ready, bank_we, bank_re, rd_valid, mux_en, mux_sel}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b af=%b rdy=%b we=%b re=%b v=%b en=%b sel=%0d",
               count, empty, full, almost_full, wr_ready, bank_we, bank_re, rd_valid, mux_en,
               mux_sel);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_four_writes();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = vals[i];
      #1;
      checks++;
      if (bank_we !== 4'(1 << i) || bank_waddr !== '0) begin
        errors++;
        $display("FAIL write_stripe%0d: got we=%b addr=%0d want %b 0", i, bank_we, bank_waddr,
                 4'(1 << i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (rd_valid !== 1'b0) begin
          errors++; $display("FAIL early_valid: got %b want 0", rd_valid);
        end
      end
      if (i == 1) begin
        checks++;
        if (rd_valid !== 1'b1 || mux_sel !== 2'd0) begin
          errors++; $display("FAIL first_valid: got v=%b sel=%0d want 1 0", rd_valid, mux_sel);
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || mux_sel !== 2'(i) || mux_out !== vals[i]) begin
        errors++;
        $display("FAIL drain%0d: got v=%b sel=%0d d=%h want 1 %0d %h", i, rd_valid, mux_sel,
                 mux_out, i, vals[i]);
      end
      tick();
    end
    checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL drain_end: got v=%b empty=%b want 0 1", rd_valid, empty);
    end
  endtask

  task automatic test_full();
    do_reset();
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 40 && full !== 1'b1; i++) begin
      wr_data = 8'(i * 7 + 3);
      tick();
    end
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || almost_full !== AF_ON) begin
      errors++;
      $display("FAIL full_state: got full=%b cnt=%0d af=%b want 1 16 %b", full, count,
               almost_full, AF_ON);
    end
    wr_data = 8'hEE;
    #1;
    checks++;
    if (bank_we !== 4'b0000 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL write_when_full: got we=%b rdy=%b want 0000 0", bank_we, wr_ready);
    end
    tick();
    drain_all();
  endtask

  task automatic test_stream();
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      tick();
      if (i >= 1) begin
        checks++;
        if (count !== 5'd1) begin
          errors++; $display("FAIL stream_count%0d: got %0d want 1", i, count);
        end
      end
    end
    drain_all();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_data  = 8'($urandom);
      rd_ready = ($urandom_range(0, 9) < ((i / 100) == 1 ? 2 : 6));
      tick();
    end
    drain_all();
  endtask

  task automatic test_stall();
    logic [7:0] vals [3];
    vals = '{8'hC1, 8'hC2, 8'hC3};
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = vals[i];
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rd_valid !== 1'b1 || bank_re !== 4'b0 || mux_sel !== 2'd0 || mux_out !== vals[0]) begin
        errors++;
        $display("FAIL stall%0d: got v=%b re=%b sel=%0d d=%h want 1 0000 0 %h", i, rd_valid,
                 bank_re, mux_sel, mux_out, vals[0]);
      end
      tick();
    end
    rd_ready = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || mux_sel !== 2'd1 || mux_out !== vals[1]) begin
      errors++;
      $display("FAIL stall_release: got v=%b sel=%0d d=%h want 1 1 %h", rd_valid, mux_sel,
               mux_out, vals[1]);
    end
    drain_all();
  endtask

  task automatic test_mid_reset();
    do_reset();
    rd_ready = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 20 && count !== 5'd7; i++) begin
      wr_data = 8'(i + 8'h40);
      tick();
    end
    wr_valid = 1'b0;
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL prefill: got %0d want 7", count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || rd_valid !== 1'b0 || mux_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d v=%b en=%b want 0 0 0", count, rd_valid, mux_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    #1;
    checks++;
    if (bank_we !== 4'b0001 || bank_waddr !== '0) begin
      errors++; $display("FAIL post_reset_write: got we=%b addr=%0d want 0001 0", bank_we, bank_waddr);
    end
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 10 && rd_valid !== 1'b1; i++) tick();
    checks++;
    if (rd_valid !== 1'b1 || mux_sel !== 2'd0 || mux_out !== 8'hA5) begin
      errors++;
      $display("FAIL post_reset_read: got v=%b sel=%0d d=%h want 1 0 a5", rd_valid, mux_sel,
               mux_out);
    end
    drain_all();
  endtask

  initial begin
    test_reset();
    test_four_writes();
    test_drain();
    test_full();
    test_stream();
    test_stall();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
